hgw_sram_fifo_ctrl: RTL and testbench

- Streaming FIFO controller that acts as the master of a single-port synchronous SRAM, with the hgw_sram_ff port style: ce/we high active, 1-cycle read latency.
- Converts a valid/ready write stream and a valid/ready read stream into SRAM accesses.
- Arbitrates the single port between the two streams.
- Absorbs the SRAM read latency with a 2-entry output skid buffer.
- Used wherever a deep, FIFO-ordered buffer must live in an SRAM macro instead of flops.

---
 rtl/hgw_sram_fifo_ctrl.sv | 139 +++++++++++++
 tb/tb_hgw_sram_fifo_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hgw_sram_fifo_ctrl.sv
// hgw_sram_fifo_ctrl: FIFO of D+2 words kept in an external single-port SRAM (ce/we active-high, 1-cycle read) plus a 2-entry output skid buffer.
// Latency: a word accepted in cycle t on an empty FIFO shows out_valid in t+3; with both sides busy the SRAM alternates write/read (1 word per 2 cycles).
// Backpressure: in_ready drops when the SRAM is full or a read holds priority; reads pause while the skid buffer plus in-flight read would exceed 2. Optional flush port under HGW_SRAM_FIFO_FLUSH_EN.
module hgw_sram_fifo_ctrl #(
    parameter int D  = 128,
    parameter int W  = 32,
    parameter int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
`ifdef HGW_SRAM_FIFO_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [W-1:0]  sram_wdata,
    input  logic [W-1:0]  sram_rdata,
    output logic [AW+1:0] count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0]   MEM_FULL = (AW+1)'(D);
    localparam logic [AW+1:0] CAP      = (AW+2)'(D + 2);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   mem_cnt;
    logic          rd_inflight;
    logic [1:0]    ob_cnt;
    logic [W-1:0]  ob_tail;
    logic          rr;          // 0: read wins the next contention, 1: write wins
    logic          clr;         // clears pointers/counters this edge (reset or flush)
    logic          rd_want;
    logic          wr_go;
    logic          rd_go;
    logic          pop;
    logic          push;

`ifdef HGW_SRAM_FIFO_FLUSH_EN
    assign clr = rst | flush;
`else
    assign clr = rst;
`endif

    // A read is only worth issuing if its data is guaranteed a slot in the skid buffer.
    assign rd_want = (mem_cnt != '0) && (({1'b0, ob_cnt} + {2'b00, rd_inflight}) < 3'd2);

    assign in_ready = !clr && (mem_cnt != MEM_FULL) && !(rd_want && !rr);
    assign wr_go    = in_valid && in_ready;
    assign rd_go    = !clr && rd_want && !wr_go;

    // Address/wdata are don't-care while ce is low, so a plain mux suffices.
    assign sram_ce    = wr_go | rd_go;
    assign sram_we    = wr_go;
    assign sram_addr  = wr_go ? wptr : rptr;
    assign sram_wdata = in_data;

    assign out_valid = (ob_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = rd_inflight;

    assign count = {1'b0, mem_cnt} + {{(AW+1){1'b0}}, rd_inflight} + {{AW{1'b0}}, ob_cnt};
    assign full  = (count == CAP);
    assign empty = (count == '0);

    // SRAM-side bookkeeping: pointers, word count, read-in-flight flag and round-robin bit.
    always_ff @(posedge clk) begin
        if (clr) begin
            wptr        <= '0;
            rptr        <= '0;
            mem_cnt     <= '0;
            rd_inflight <= 1'b0;
            rr          <= 1'b0;
        end else begin
            if (wr_go) begin
                wptr    <= wptr + 1'b1;
                mem_cnt <= mem_cnt + 1'b1;
            end else if (rd_go) begin
                rptr    <= rptr + 1'b1;
                mem_cnt <= mem_cnt - 1'b1;
            end
            rd_inflight <= rd_go;
            if (rd_want && wr_go) begin
                rr <= 1'b0;
            end else if (rd_go && in_valid) begin
                rr <= 1'b1;
            end
        end
    end

    // Two-entry in-order skid buffer; out_data is the registered head, ob_tail the second slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ob_cnt   <= 2'd0;
            out_data <= '0;
            ob_tail  <= '0;
        end else if (clr) begin
            ob_cnt <= 2'd0;     // flush drops contents but leaves out_data as-is
        end else begin
            case (ob_cnt)
                2'd0: begin
                    if (push) begin
                        out_data <= sram_rdata;
                        ob_cnt   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        out_data <= sram_rdata;
                    end else if (push) begin
                        ob_tail <= sram_rdata;
                        ob_cnt  <= 2'd2;
                    end else if (pop) begin
                        ob_cnt <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        out_data <= ob_tail;
                        if (push) begin
                            ob_tail <= sram_rdata;
                        end else begin
                            ob_cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hgw_sram_fifo_ctrl.sv
// tb_hgw_sram_fifo_ctrl: directed vector table plus multi-cycle sequences against a behavioural SRAM.
// Latency: outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: exercised through table rows, fill/drain, continuous streaming and pseudo-random valid/ready.
module tb_hgw_sram_fifo_ctrl;

    localparam int D  = 128;
    localparam int W  = 32;
    localparam int AW = 7;
    localparam int NV = 16;

    logic          clk = 1'b0;
    logic          rst;
`ifdef HGW_SRAM_FIFO_FLUSH_EN
    logic          flush;
`endif
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          sram_ce;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [W-1:0]  sram_wdata;
    logic [W-1:0]  sram_rdata;
    logic [AW+1:0] count;
    logic          full;
    logic          empty;

    always #5 clk = ~clk;

    hgw_sram_fifo_ctrl #(.D(D), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef HGW_SRAM_FIFO_FLUSH_EN
        .flush      (flush),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // Behavioural single-port SRAM: write or 1-cycle-latency read when ce is high.
    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    typedef struct {
        logic          iv;
        logic [31:0]   id;
        logic          ordy;
        logic          irdy;
        logic          ce;
        logic          we;
        logic [AW-1:0] ad;
        logic          ov;
        logic [31:0]   od;
        logic [AW+1:0] cnt;
    } vec_t;

    vec_t tbl [NV];

    int total = 0;
    int bad   = 0;

    logic [W-1:0]  sb [$];
    int            pushed, popped, cnt_err, ord_err, op_err, alt_err, wraps, got, acc, idx, derr;
    bit            found;
    logic          s_ce, s_we, prev_we;
    logic [AW-1:0] s_addr;
    logic [31:0]   rs;

    function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ordy,
                                input logic irdy, input logic ce, input logic we, input logic [AW-1:0] ad,
                                input logic ov, input logic [31:0] od, input logic [AW+1:0] cnt);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.irdy = irdy; v.ce = ce; v.we = we;
        v.ad = ad; v.ov = ov; v.od = od; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        r = r ^ (r << 13);
        r = r ^ (r >> 17);
        r = r ^ (r << 5);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One cycle with scoreboard tracking; inputs must already be driven.
    task automatic sb_cycle();
        @(negedge clk);
        s_ce   = sram_ce;
        s_we   = sram_we;
        s_addr = sram_addr;
        if (count !== (AW+2)'(sb.size())) cnt_err++;
        if (sram_we && !sram_ce) op_err++;
        if ((sram_ce && sram_we) !== (in_valid && in_ready)) op_err++;
        if (sram_ce && sram_we && (sram_wdata !== in_data)) op_err++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) ord_err++;
            else begin
                if (out_data !== sb[0]) ord_err++;
                void'(sb.pop_front());
            end
            popped++;
        end
        if (in_valid && in_ready) begin
            sb.push_back(in_data);
            pushed++;
        end
        @(posedge clk); #1;
    endtask

    task automatic push_n(input int n, input logic [31:0] base, output int cnt);
        cnt = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20 * n && cnt < n; i++) begin
            in_data = base + 32'(cnt);
            @(negedge clk);
            if (in_ready) cnt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_rd(output bit f);
        f = 1'b0;
        for (int i = 0; i < 20 && !f; i++) begin
            @(negedge clk);
            f = sram_ce && !sram_we;
            @(posedge clk); #1;
        end
    endtask

    task automatic first_out(input string nm, input logic [31:0] d);
        int  n;
        bit  seen;
        seen = 1'b0;
        out_ready = 1'b1;
        push_n(1, d, n);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                chk(nm, out_data, d);
            end
            @(posedge clk); #1;
        end
        chk({nm, " seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        // Hand-derived cycle table starting right after reset.
        tbl[0]  = mk(1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b1, 1'b1, 7'd0, 1'b0, 32'h0,         9'd0);
        tbl[1]  = mk(1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 32'h0,         9'd1);
        tbl[2]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 32'h0,         9'd1);
        tbl[3]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 1'b1, 32'hA5A5_0001, 9'd1);
        tbl[4]  = mk(1'b1, 32'hB1,        1'b0, 1'b1, 1'b1, 1'b1, 7'd1, 1'b0, 32'h0,         9'd0);
        tbl[5]  = mk(1'b1, 32'hB2,        1'b0, 1'b0, 1'b1, 1'b0, 7'd1, 1'b0, 32'h0,         9'd1);
        tbl[6]  = mk(1'b1, 32'hB2,        1'b0, 1'b1, 1'b1, 1'b1, 7'd2, 1'b0, 32'h0,         9'd1);
        tbl[7]  = mk(1'b1, 32'hB3,        1'b0, 1'b1, 1'b1, 1'b1, 7'd3, 1'b1, 32'hB1,        9'd2);
        tbl[8]  = mk(1'b1, 32'hB4,        1'b0, 1'b0, 1'b1, 1'b0, 7'd2, 1'b1, 32'hB1,        9'd3);
        tbl[9]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b1, 32'hB1,        9'd3);
        tbl[10] = mk(1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b1, 32'hB1,        9'd3);
        tbl[11] = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 1'b1, 32'hB1,        9'd3);
        tbl[12] = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 7'd3, 1'b1, 32'hB2,        9'd2);
        tbl[13] = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 32'h0,         9'd1);
        tbl[14] = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 1'b1, 32'hB3,        9'd1);
        tbl[15] = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 32'h0,         9'd0);

        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
`ifdef HGW_SRAM_FIFO_FLUSH_EN
        flush = 1'b0;
`endif
        pushed = 0; popped = 0; cnt_err = 0; ord_err = 0; op_err = 0; alt_err = 0; wraps = 0;
        prev_we = 1'b0; rs = 32'h1BAD_5EED;

        // Reset state, with in_valid high to show in_ready/ce are gated by rst.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready",  32'(in_ready),  32'd0);
        chk("rst sram_ce",   32'(sram_ce),   32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data",  out_data,       32'd0);
        chk("rst count",     32'(count),     32'd0);
        chk("rst empty",     32'(empty),     32'd1);
        chk("rst full",      32'(full),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Vector table.
        for (int i = 0; i < NV; i++) begin
            in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(tbl[i].irdy));
            chk($sformatf("v%0d sram_ce", i),   32'(sram_ce),   32'(tbl[i].ce));
            chk($sformatf("v%0d sram_we", i),   32'(sram_we),   32'(tbl[i].we));
            if (tbl[i].ce) chk($sformatf("v%0d sram_addr", i), 32'(sram_addr), 32'(tbl[i].ad));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov) chk($sformatf("v%0d out_data", i), out_data, tbl[i].od);
            chk($sformatf("v%0d count", i),     32'(count),     32'(tbl[i].cnt));
            chk($sformatf("v%0d empty", i),     32'(empty),     32'(tbl[i].cnt == '0));
            @(posedge clk); #1;
        end

        // Fill to capacity with out_ready low.
        in_valid = 1'b1; out_ready = 1'b0; acc = 0;
        for (int i = 0; i < 600; i++) begin
            in_data = 32'(acc);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("fill accepted", 32'(acc),      32'(D + 2));
        chk("fill count",    32'(count),    32'(D + 2));
        chk("fill full",     32'(full),     32'd1);
        chk("fill in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;

        // Drain and check order.
        out_ready = 1'b1; idx = 0; derr = 0;
        for (int i = 0; i < 1000 && idx < D + 2; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (out_data !== 32'(idx)) derr++;
                idx++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain words",  32'(idx),   32'(D + 2));
        chk("drain order",  32'(derr),  32'd0);
        chk("drain empty",  32'(empty), 32'd1);
        chk("drain count",  32'(count), 32'd0);
        @(posedge clk); #1;

        // Continuous streaming: write/read strictly alternate once primed.
        in_valid = 1'b1; out_ready = 1'b1; pushed = 0; popped = 0;
        for (int i = 0; i < 2400; i++) begin
            in_data = 32'h1000_0000 + 32'(pushed);
            sb_cycle();
            if (i >= 4 && (!s_ce || (s_we == prev_we))) alt_err++;
            prev_we = s_we;
            if (s_ce && s_we && (s_addr == AW'(D - 1))) wraps++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 50 && sb.size() != 0; i++) sb_cycle();
        chk("stream alternate", 32'(alt_err),         32'd0);
        chk("stream wraps>=7",  32'(wraps >= 7),      32'd1);
        chk("stream order",     32'(ord_err),         32'd0);
        chk("stream count",     32'(cnt_err),         32'd0);
        chk("stream drained",   32'(sb.size()),       32'd0);

        // Pseudo-random valid/ready, 10k words.
        pushed = 0; popped = 0;
        for (int i = 0; i < 80000 && !(pushed >= 10000 && sb.size() == 0); i++) begin
            rs = xs(rs);
            in_valid  = (pushed < 10000) && rs[3];
            out_ready = rs[11];
            in_data   = 32'h5000_0000 + 32'(pushed);
            sb_cycle();
        end
        chk("rand pushed",  32'(pushed),  32'd10000);
        chk("rand popped",  32'(popped),  32'd10000);
        chk("rand order",   32'(ord_err), 32'd0);
        chk("rand count",   32'(cnt_err), 32'd0);
        chk("rand sram op", 32'(op_err),  32'd0);

        // Reset in the cycle after a read issue.
        in_valid = 1'b0; out_ready = 1'b0;
        push_n(5, 32'h7000_0000, got);
        chk("rstmid pushed", 32'(got), 32'd5);
        out_ready = 1'b1;
        wait_rd(found);
        chk("rstmid read seen", 32'(found), 32'd1);
        rst = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid count",     32'(count),     32'd0);
        chk("rstmid out_valid", 32'(out_valid), 32'd0);
        chk("rstmid in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        first_out("rstmid first", 32'h1234);

`ifdef HGW_SRAM_FIFO_FLUSH_EN
        // Flush pulse while a read's data is arriving.
        out_ready = 1'b0;
        push_n(10, 32'h9000_0000, got);
        chk("flush pushed", 32'(got), 32'd10);
        out_ready = 1'b1;
        wait_rd(found);
        chk("flush read seen", 32'(found), 32'd1);
        flush = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        chk("flush in_ready", 32'(in_ready), 32'd0);
        chk("flush sram_ce",  32'(sram_ce),  32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush count",     32'(count),     32'd0);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush stale count", 32'(count), 32'd0);
        @(posedge clk); #1;
        first_out("flush first", 32'hBEEF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
